gbinstr_issuer: RTL and testbench

GBINSTR_ISSUER -- requirements
Module: gbinstr_issuer

---
 rtl/gbprocessor_pkg.sv | 16 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/gbinstr_issuer.sv | 115 +++++++++++
 tb/tb_gbinstr_issuer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gbprocessor_pkg.sv
// Shared constants for the instruction issuer: FSM state encodings, default
// FIFO depth / inter-instruction gap and the instruction driven while idle.
package gbprocessor_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_GAP   = 0;

  localparam logic [7:0] IDLE_INSTR = 8'h00;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; pointers carry one extra wrap
// bit so full and empty are distinguishable. Storage is not reset.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/gbinstr_issuer.sv
// Buffers host-written instruction bytes, then on start issues them to the
// processor one per ISSUE cycle and captures the register snapshot at the end.
module gbinstr_issuer
  import gbprocessor_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     start,
  output logic [7:0]               instruction,
  output logic                     valid,
  input  logic [63:0]              probe,
  output logic                     busy,
  output logic                     done,
  output logic [63:0]              result,
  output logic [$clog2(DEPTH):0]   issued_cnt,
  output logic [2:0]               o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [2:0]    r_state;
  logic [GW-1:0] r_gap_cnt;
  logic [AW:0]   r_issued_cnt;
  logic [63:0]   r_result;

  logic          w_in_idle;
  logic          w_in_issue;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic          w_last;
  logic [7:0]    w_head;
  logic [AW:0]   w_level;

  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_in_issue = (r_state == ST_ISSUE);

  // Host write handshake: a byte transfers on a clock edge where wr_valid and
  // wr_ready are both high; wr_ready depends only on state and FIFO fullness.
  assign wr_ready = w_in_idle && !w_full;
  assign w_push   = wr_valid && wr_ready;
  assign w_last   = (w_level == (AW+1)'(1));

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_din   (wr_data),
    .i_pop   (w_in_issue),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_gap_cnt    <= '0;
      r_issued_cnt <= '0;
      r_result     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A write accepted on the start edge counts toward this run.
          if (start) begin
            r_issued_cnt <= '0;
            r_state      <= (w_empty && !w_push) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_issued_cnt <= r_issued_cnt + (AW+1)'(1);
          if (w_last) begin
            r_state <= ST_DRAIN;
          end else if (GAP > 0) begin
            r_state   <= ST_WAIT;
            r_gap_cnt <= GAP_RELOAD;
          end else begin
            r_state <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (r_gap_cnt == '0) r_state <= ST_ISSUE;
          else r_gap_cnt <= r_gap_cnt - GW'(1);
        end
        ST_DRAIN: begin
          r_result <= probe;
          r_state  <= ST_DONE;
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign valid       = w_in_issue;
  assign instruction = w_in_issue ? w_head : IDLE_INSTR;
  assign busy        = !w_in_idle;
  assign done        = (r_state == ST_DONE);
  assign result      = r_result;
  assign issued_cnt  = r_issued_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gbinstr_issuer.sv
// Directed bench for gbinstr_issuer: one instance with GAP=0 and one with
// GAP=2, driven from a run table plus full-FIFO and mid-run reset sequences.
module tb_gbinstr_issuer;
  import gbprocessor_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  wr_data;
  logic        wr_valid_a, wr_valid_b;
  logic        start_a, start_b;
  logic [63:0] probe;

  logic        wr_ready_a, wr_ready_b, valid_a, valid_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [7:0]  instr_a, instr_b;
  logic [63:0] result_a, result_b;
  logic [4:0]  cnt_a, cnt_b;
  logic [2:0]  dbg_a, dbg_b;

  logic        sel_b;
  logic        m_valid, m_done, m_busy, m_ready;
  logic [7:0]  m_instr;
  logic [63:0] m_result;
  logic [4:0]  m_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  gbinstr_issuer #(.DEPTH(16), .GAP(0)) u_dut_a (
    .clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid_a),
    .wr_ready(wr_ready_a), .start(start_a), .instruction(instr_a),
    .valid(valid_a), .probe(probe), .busy(busy_a), .done(done_a),
    .result(result_a), .issued_cnt(cnt_a), .o_dbg_state(dbg_a)
  );

  gbinstr_issuer #(.DEPTH(16), .GAP(2)) u_dut_b (
    .clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid_b),
    .wr_ready(wr_ready_b), .start(start_b), .instruction(instr_b),
    .valid(valid_b), .probe(probe), .busy(busy_b), .done(done_b),
    .result(result_b), .issued_cnt(cnt_b), .o_dbg_state(dbg_b)
  );

  assign m_valid  = sel_b ? valid_b    : valid_a;
  assign m_done   = sel_b ? done_b     : done_a;
  assign m_busy   = sel_b ? busy_b     : busy_a;
  assign m_ready  = sel_b ? wr_ready_b : wr_ready_a;
  assign m_instr  = sel_b ? instr_b    : instr_a;
  assign m_result = sel_b ? result_b   : result_a;
  assign m_cnt    = sel_b ? cnt_b      : cnt_a;

  typedef struct {
    bit          sel;
    int          n;
    logic [31:0] prog;     // byte 0 is issued first
    bit          last_w;   // last byte written in the start cycle
    int          inj;      // cycle index to inject start+write mid-run (0 = none)
    logic [63:0] pv;
    logic [63:0] exp_res;
    int          exp_cyc;  // cycles from start cycle through done, inclusive
    int          exp_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_wr(input logic v);
    wr_valid_a = v && !sel_b;
    wr_valid_b = v && sel_b;
  endtask

  task automatic drive_start(input logic v);
    start_a = v && !sel_b;
    start_b = v && sel_b;
  endtask

  task automatic do_write(input logic [7:0] b, input logic exp_acc);
    check("wr_ready", m_ready, exp_acc);
    wr_data = b;
    drive_wr(1'b1);
    @(posedge clock); #1;
    drive_wr(1'b0);
    if (exp_acc) exp_q.push_back(b);
  endtask

  task automatic do_run(input int n_exp, input int gap, input logic [63:0] pv,
                        input logic [63:0] exp_res, input bit with_wr,
                        input logic [7:0] wb, input int inj, input int exp_cyc);
    int cyc, pulses, last, bad_busy, bad_idle;
    logic [7:0] e;
    probe = pv;
    if (with_wr) begin
      wr_data = wb;
      drive_wr(1'b1);
      exp_q.push_back(wb);
    end
    drive_start(1'b1);
    cyc = 1; pulses = 0; last = 0; bad_busy = 0; bad_idle = 0;
    while (cyc < 100) begin
      @(posedge clock); #1;
      drive_start(1'b0);
      drive_wr(1'b0);
      cyc++;
      if (cyc == inj) begin
        check("ready_when_busy", m_ready, 1'b0);
        wr_data = 8'hEE;
        drive_wr(1'b1);
        drive_start(1'b1);
      end
      if (m_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("instruction", m_instr, e);
        if (pulses > 0) check("pulse_spacing", cyc - last, gap + 1);
        last = cyc;
        pulses++;
      end else if (m_instr !== IDLE_INSTR) begin
        bad_idle++;
      end
      if (m_done) break;
      if (!m_busy) bad_busy++;
    end
    check("done_seen", m_done, 1'b1);
    check("run_cycles", cyc, exp_cyc);
    check("valid_pulses", pulses, n_exp);
    check("issued_cnt", m_cnt, n_exp);
    check("result", m_result, exp_res);
    check("idle_instr_cycles", bad_idle, 0);
    check("not_busy_in_run", bad_busy, 0);
    @(posedge clock); #1;
    probe = ~pv;
    check("done_one_cycle", m_done, 1'b0);
    check("busy_after_done", m_busy, 1'b0);
    @(posedge clock); #1;
    check("result_hold", m_result, exp_res);
    check("cnt_hold", m_cnt, n_exp);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, bad;
    logic [7:0] wb;
    logic [63:0] pv;

    tbl[0] = '{1'b0, 1, 32'h0000_0080, 1'b0, 0, 64'h0100_0000_0000_0000, 64'h0100_0000_0000_0000, 4, 1};
    tbl[1] = '{1'b0, 3, 32'h0082_8180, 1'b0, 0, 64'h0600_0000_0000_0001, 64'h0600_0000_0000_0001, 6, 3};
    tbl[2] = '{1'b1, 3, 32'h0030_2010, 1'b0, 0, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 10, 3};
    tbl[3] = '{1'b0, 0, 32'h0000_0000, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0600_0000_0000_0001, 2, 0};
    tbl[4] = '{1'b1, 2, 32'h0000_5AA5, 1'b1, 0, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 7, 2};
    tbl[5] = '{1'b1, 0, 32'h0000_0000, 1'b0, 0, 64'h0, 64'h1111_2222_3333_4444, 2, 0};
    tbl[6] = '{1'b1, 2, 32'h0000_2211, 1'b0, 3, 64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888, 7, 2};
    tbl[7] = '{1'b1, 0, 32'h0000_0000, 1'b0, 0, 64'h9, 64'h5555_6666_7777_8888, 2, 0};

    // Clock/reset
    reset = 1'b0; wr_data = 8'h00; wr_valid_a = 1'b0; wr_valid_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0; probe = 64'hA5A5_A5A5_A5A5_A5A5; sel_b = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", valid_a, 1'b0);
    check("rst_instruction", instr_a, 8'h00);
    check("rst_done", done_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_issued_cnt", cnt_a, 5'd0);
    check("rst_result", result_a, 64'h0);
    check("rst_wr_ready", wr_ready_a, 1'b1);
    check("rst_state", dbg_a, ST_IDLE);
    check("rst_busy_b", busy_b, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Table-driven runs
    for (int i = 0; i < 8; i++) begin
      sel_b = tbl[i].sel;
      nw = tbl[i].last_w ? tbl[i].n - 1 : tbl[i].n;
      for (int j = 0; j < nw; j++) do_write(tbl[i].prog[8*j +: 8], 1'b1);
      wb = 8'h00;
      if (tbl[i].last_w) wb = tbl[i].prog[8*(tbl[i].n-1) +: 8];
      do_run(tbl[i].exp_cnt, tbl[i].sel ? 2 : 0, tbl[i].pv, tbl[i].exp_res,
             tbl[i].last_w, wb, tbl[i].inj, tbl[i].exp_cyc);
    end

    // Full FIFO: 17th byte dropped, 16 issued back-to-back
    sel_b = 1'b0;
    for (int i = 0; i < 17; i++) do_write(8'(8'h40 + i), (i < 16) ? 1'b1 : 1'b0);
    check("full_wr_ready", m_ready, 1'b0);
    pv = 64'h0F0E_0D0C_0B0A_0908;
    do_run(16, 0, pv, pv, 1'b0, 8'h00, 0, 19);

    // Reset during the second ISSUE cycle of a 4-instruction run
    for (int i = 0; i < 4; i++) do_write(8'(8'h01 + i), 1'b1);
    drive_start(1'b1);
    @(posedge clock); #1;
    drive_start(1'b0);
    check("mid_rst_valid1", m_valid, 1'b1);
    check("mid_rst_instr1", m_instr, 8'h01);
    @(posedge clock); #1;
    check("mid_rst_valid2", m_valid, 1'b1);
    check("mid_rst_instr2", m_instr, 8'h02);
    reset = 1'b0;
    @(posedge clock); #1;
    check("mid_rst_valid_off", m_valid, 1'b0);
    check("mid_rst_instr_off", m_instr, 8'h00);
    check("mid_rst_busy", m_busy, 1'b0);
    check("mid_rst_done", m_done, 1'b0);
    check("mid_rst_cnt", m_cnt, 5'd0);
    check("mid_rst_state", dbg_a, ST_IDLE);
    reset = 1'b1;
    exp_q.delete();
    bad = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (valid_a || done_a) bad++;
    end
    check("mid_rst_no_activity", bad, 0);
    do_run(0, 0, 64'h7, 64'h0, 1'b0, 8'h00, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
